piradip_axis_pkt_arbiter: RTL and testbench

- Packet-aware round-robin arbiter. Merges N_PORTS AXI4-Stream subordinate inputs onto one AXI4-Stream manager output.
- A grant is held from the first beat of a packet through its tlast beat, so packets never interleave.
- Output is registered (one register slice). m_tid carries the source port index.
- Sits in front of shared sinks, e.g. DMA write channels or a single framer fed by several sample streams.

---
 rtl/piradip_axis_pkg.sv | 30 +++
 rtl/piradip_rr_pick.sv | 36 +++
 rtl/piradip_axis_pkt_arbiter.sv | 108 ++++++++++
 tb/tb_piradip_axis_pkt_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/piradip_axis_pkg.sv
// Shared types and a reference round-robin pick for the AXI-Stream packet arbiter.
package piradip_axis_pkg;

   typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

   localparam int RR_MAX_PORTS = 16;

   typedef struct packed {
      logic       valid;
      logic [3:0] idx;
   } rr_result_t;

   // Behavioural reference: first set bit of req at or above ptr, wrapping modulo n.
   function automatic rr_result_t rr_pick(input logic [RR_MAX_PORTS-1:0] req,
                                          input logic [3:0] ptr,
                                          input int n);
      rr_result_t r;
      int p;
      r = '0;
      for (int k = n - 1; k >= 0; k--) begin
         p = (int'(ptr) + k) % n;
         if (req[p]) begin
            r.valid = 1'b1;
            r.idx   = p[3:0];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/piradip_rr_pick.sv
// Combinational round-robin pick: rotate the request vector by ptr, then priority-encode.
module piradip_rr_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          valid,
   output logic [IW-1:0] idx
);

   localparam logic [IW:0] N_W = (IW + 1)'(N);

   logic [2*N-1:0] req_dbl;
   logic [N-1:0]   req_rot;
   logic [IW-1:0]  ofs;
   logic [IW:0]    sum;

   always_comb begin
      req_dbl = {req, req};
      req_rot = req_dbl[ptr +: N];
      valid   = 1'b0;
      ofs     = '0;
      // Descending scan so the lowest offset from ptr wins.
      for (int i = N - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            valid = 1'b1;
            ofs   = IW'(i);
         end
      end
      sum = {1'b0, ptr} + {1'b0, ofs};
      if (sum >= N_W) sum = sum - N_W;
      idx = sum[IW-1:0];
   end

endmodule

// File: rtl/piradip_axis_pkt_arbiter.sv
// Packet-aware round-robin AXI4-Stream merger: grant held from first beat to tlast,
// single registered output slice, m_tid carries the source port.
module piradip_axis_pkt_arbiter
   import piradip_axis_pkg::*;
#(
   parameter int N_PORTS  = 4,
   parameter int WIDTH    = 32,
   parameter int ID_WIDTH = $clog2(N_PORTS)
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic [N_PORTS-1:0]          s_tvalid,
   output logic [N_PORTS-1:0]          s_tready,
   input  logic [N_PORTS-1:0]          s_tlast,
   input  logic [N_PORTS*WIDTH-1:0]    s_tdata,
   input  logic [N_PORTS*WIDTH/8-1:0]  s_tkeep,
   input  logic [N_PORTS-1:0]          port_enable,
   output logic                        m_tvalid,
   input  logic                        m_tready,
   output logic                        m_tlast,
   output logic [WIDTH-1:0]            m_tdata,
   output logic [WIDTH/8-1:0]          m_tkeep,
   output logic [ID_WIDTH-1:0]         m_tid,
   output logic                        busy,
   output logic [ID_WIDTH-1:0]         grant
);

   localparam int KW = WIDTH / 8;
   localparam logic [ID_WIDTH-1:0] LAST_PORT = ID_WIDTH'(N_PORTS - 1);

   arb_state_t           state;
   logic [ID_WIDTH-1:0]  rr_ptr;
   logic [N_PORTS-1:0]   req;
   logic                 pick_vld;
   logic [ID_WIDTH-1:0]  pick_idx;
   logic                 out_free;
   logic                 vld_p0;
   logic                 last_p0;
   logic [WIDTH-1:0]     data_p0;
   logic [KW-1:0]        keep_p0;

   assign req = s_tvalid & port_enable;

   piradip_rr_pick #(
      .N  (N_PORTS),
      .IW (ID_WIDTH)
   ) u_pick (
      .req   (req),
      .ptr   (rr_ptr),
      .valid (pick_vld),
      .idx   (pick_idx)
   );

   // Stage p0: granted-port mux; ready follows the output slot combinationally.
   always_comb begin
      out_free = !m_tvalid || m_tready;
      s_tready = '0;
      if (state == ARB_BUSY) s_tready[grant] = out_free;
      vld_p0  = (state == ARB_BUSY) && s_tvalid[grant] && out_free;
      data_p0 = s_tdata[int'(grant)*WIDTH +: WIDTH];
      keep_p0 = s_tkeep[int'(grant)*KW +: KW];
      last_p0 = s_tlast[grant];
   end

   // Stage p1: output register slice plus arbitration FSM.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state    <= ARB_IDLE;
         rr_ptr   <= '0;
         grant    <= '0;
         busy     <= 1'b0;
         m_tvalid <= 1'b0;
         m_tlast  <= 1'b0;
         m_tdata  <= '0;
         m_tkeep  <= '0;
         m_tid    <= '0;
      end else begin
         if (vld_p0) begin
            m_tvalid <= 1'b1;
            m_tdata  <= data_p0;
            m_tkeep  <= keep_p0;
            m_tlast  <= last_p0;
            m_tid    <= grant;
         end else if (m_tready) begin
            m_tvalid <= 1'b0;
         end

         case (state)
            ARB_IDLE: begin
               if (pick_vld) begin
                  grant <= pick_idx;
                  busy  <= 1'b1;
                  state <= ARB_BUSY;
               end
            end
            ARB_BUSY: begin
               if (vld_p0 && last_p0) begin
                  rr_ptr <= (grant == LAST_PORT) ? '0 : grant + ID_WIDTH'(1);
                  busy   <= 1'b0;
                  state  <= ARB_IDLE;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_piradip_axis_pkt_arbiter.sv
// Bench for piradip_axis_pkt_arbiter: per-port source queues, output scoreboard,
// a vector table of traffic scenarios and hand-written latency/enable/reset sequences.
module tb_piradip_axis_pkt_arbiter;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int KW = W / 8;
   localparam int IW = 2;

   logic            aclk = 1'b0;
   logic            aresetn;
   logic [N-1:0]    s_tvalid;
   logic [N-1:0]    s_tready;
   logic [N-1:0]    s_tlast;
   logic [N*W-1:0]  s_tdata;
   logic [N*KW-1:0] s_tkeep;
   logic [N-1:0]    port_enable;
   logic            m_tvalid;
   logic            m_tready;
   logic            m_tlast;
   logic [W-1:0]    m_tdata;
   logic [KW-1:0]   m_tkeep;
   logic [IW-1:0]   m_tid;
   logic            busy;
   logic [IW-1:0]   grant;

   always #5 aclk = ~aclk;

   piradip_axis_pkt_arbiter #(.N_PORTS(N), .WIDTH(W)) dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .s_tvalid    (s_tvalid),
      .s_tready    (s_tready),
      .s_tlast     (s_tlast),
      .s_tdata     (s_tdata),
      .s_tkeep     (s_tkeep),
      .port_enable (port_enable),
      .m_tvalid    (m_tvalid),
      .m_tready    (m_tready),
      .m_tlast     (m_tlast),
      .m_tdata     (m_tdata),
      .m_tkeep     (m_tkeep),
      .m_tid       (m_tid),
      .busy        (busy),
      .grant       (grant)
   );

   typedef struct {
      logic [3:0] en;
      logic [3:0] act;
      int         plen;
      int         npk;
      logic [3:0] rdy;
      bit         gap;
      int         nexp;
      int         ord[12];
   } vec_t;

   vec_t        vecs[5];
   logic [36:0] srcq[N][$];   // {last, keep, data}
   logic [38:0] sb[$];        // {tid, last, keep, data}
   int          tid_log[$];
   int          t_log[$];
   bit          last_log[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   bit          prev_stall = 0;
   logic [W-1:0] prev_data = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_all();
      for (int i = 0; i < N; i++) srcq[i].delete();
      sb.delete();
      tid_log.delete();
      t_log.delete();
      last_log.delete();
      s_tvalid   = '0;
      prev_stall = 0;
   endtask

   task automatic do_reset();
      @(negedge aclk);
      aresetn  = 1'b0;
      m_tready = 1'b0;
      clear_all();
      @(negedge aclk);
      aresetn = 1'b1;
      cyc     = 0;
   endtask

   task automatic push_pkt(input int port, input int pkt, input int len);
      logic [W-1:0]  d;
      logic [KW-1:0] k;
      logic          l;
      for (int b = 0; b < len; b++) begin
         l = (b == len - 1);
         k = l ? 4'h7 : 4'hF;
         d = {4'hA, 4'(port), 8'(pkt), 16'(b)};
         srcq[port].push_back({l, k, d});
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (srcq[i].size() > 0) begin
            {s_tlast[i], s_tkeep[i*KW +: KW], s_tdata[i*W +: W]} = srcq[i][0];
            s_tvalid[i] = 1'b1;
         end else begin
            s_tvalid[i] = 1'b0;
         end
      end
   endtask

   // One clock: drive at negedge, settle, then judge the handshakes that the next posedge takes.
   task automatic step(input logic rdy);
      logic [38:0] exp;
      logic [IW-1:0] id;
      @(negedge aclk);
      m_tready = rdy;
      drive();
      #1;
      if (prev_stall) chk("stall_hold", {m_tvalid, m_tdata}, {1'b1, prev_data});
      chk("tready_grant_only", s_tready & ~(4'b0001 << grant), 0);
      if (m_tvalid && !m_tready) chk("tready_while_stalled", s_tready, 0);
      if (m_tvalid && m_tready) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got tid %0d data %0h, expected no beat", m_tid, m_tdata);
         end else begin
            exp = sb.pop_front();
            chk("beat", {m_tid, m_tlast, m_tkeep, m_tdata}, exp);
            tid_log.push_back(int'(m_tid));
            t_log.push_back(cyc);
            last_log.push_back(m_tlast);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (s_tvalid[i] && s_tready[i]) begin
            id = IW'(i);
            sb.push_back({id, srcq[i].pop_front()});
         end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      cyc++;
   endtask

   task automatic run_vec(input int idx);
      vec_t v;
      v = vecs[idx];
      do_reset();
      port_enable = v.en;
      for (int p = 0; p < N; p++)
         if (v.act[p])
            for (int k = 0; k < v.npk; k++) push_pkt(p, k, v.plen);
      for (int c = 0; c < 400 && tid_log.size() < v.nexp; c++) step(v.rdy[cyc % 4]);
      repeat (6) step(v.rdy[cyc % 4]);
      chk($sformatf("v%0d_beat_count", idx), tid_log.size(), v.nexp);
      for (int k = 0; k < v.nexp && k < tid_log.size(); k++)
         chk($sformatf("v%0d_tid[%0d]", idx, k), tid_log[k], v.ord[k]);
      if (v.gap)
         for (int k = 1; k < t_log.size(); k++)
            chk($sformatf("v%0d_spacing[%0d]", idx, k), t_log[k] - t_log[k-1], last_log[k-1] ? 2 : 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{en:4'hF, act:4'b0100, plen:4, npk:1, rdy:4'hF, gap:1, nexp:4,
                  ord:'{2,2,2,2,0,0,0,0,0,0,0,0}};
      vecs[1] = '{en:4'hF, act:4'b1011, plen:2, npk:2, rdy:4'hF, gap:1, nexp:12,
                  ord:'{0,0,1,1,3,3,0,0,1,1,3,3}};
      vecs[2] = '{en:4'hF, act:4'b0001, plen:3, npk:1, rdy:4'b1001, gap:0, nexp:3,
                  ord:'{0,0,0,0,0,0,0,0,0,0,0,0}};
      vecs[3] = '{en:4'b1011, act:4'b1111, plen:1, npk:2, rdy:4'hF, gap:1, nexp:6,
                  ord:'{0,1,3,0,1,3,0,0,0,0,0,0}};
      vecs[4] = '{en:4'hF, act:4'b0010, plen:1, npk:4, rdy:4'hF, gap:1, nexp:4,
                  ord:'{1,1,1,1,0,0,0,0,0,0,0,0}};

      aresetn     = 1'b0;
      s_tvalid    = '0;
      s_tlast     = '0;
      s_tdata     = '0;
      s_tkeep     = '0;
      port_enable = 4'hF;
      m_tready    = 1'b0;

      // Reset state, then exact latency of a 4-beat packet on port 2.
      do_reset();
      #1;
      chk("reset_outputs", {m_tvalid, s_tready, busy, grant, m_tid, m_tlast, m_tkeep, m_tdata}, 0);
      port_enable = 4'hF;
      push_pkt(2, 0, 4);
      step(1'b1);
      chk("lat_c0_idle", {s_tready, m_tvalid, busy}, 0);
      step(1'b1);
      chk("lat_c1_ready", {s_tready, busy, grant}, {4'b0100, 1'b1, 2'd2});
      step(1'b1);
      chk("lat_c2_out", {m_tvalid, m_tid, m_tlast, m_tdata}, {1'b1, 2'd2, 1'b0, 32'hA200_0000});
      repeat (3) step(1'b1);
      chk("lat_c5_end", {busy, m_tvalid, m_tlast, s_tready}, {1'b0, 1'b1, 1'b1, 4'b0000});
      step(1'b1);
      chk("lat_drained", {sb.size() == 0, tid_log.size() == 4, m_tvalid}, {1'b1, 1'b1, 1'b0});

      for (int i = 0; i < 5; i++) run_vec(i);

      // Clearing the enable of the granted port mid-packet must not cut the packet short.
      do_reset();
      port_enable = 4'hF;
      push_pkt(0, 0, 4);
      repeat (3) step(1'b1);
      port_enable = 4'b1110;
      for (int c = 0; c < 20 && tid_log.size() < 4; c++) step(1'b1);
      chk("en_clear_beats", tid_log.size(), 4);
      if (last_log.size() == 4) chk("en_clear_tlast", last_log[3], 1);
      push_pkt(0, 1, 2);
      repeat (5) step(1'b1);
      chk("en_clear_no_regrant", {busy, s_tready, tid_log.size() == 4}, {1'b0, 4'b0000, 1'b1});

      // Asynchronous reset in the middle of a port-3 packet.
      do_reset();
      port_enable = 4'hF;
      push_pkt(3, 0, 6);
      repeat (4) step(1'b1);
      chk("rst_mid_pre", {m_tvalid, busy}, 2'b11);
      #2;
      aresetn = 1'b0;
      #1;
      chk("rst_mid_async", {m_tvalid, s_tready, busy, grant, m_tid, m_tdata}, 0);
      clear_all();
      @(negedge aclk);
      aresetn = 1'b1;
      cyc     = 0;
      push_pkt(0, 0, 1);
      push_pkt(3, 0, 1);
      for (int c = 0; c < 20 && tid_log.size() < 2; c++) step(1'b1);
      chk("rst_recover_beats", tid_log.size(), 2);
      if (tid_log.size() == 2) chk("rst_recover_order", {tid_log[0], tid_log[1]}, {32'd0, 32'd3});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
